// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetcher: word PCs, queue entries
// and the NOP that ID sees while the queue is empty.
package if_pkg;

  typedef logic [29:0] word_pc_t;

  typedef struct packed {
    word_pc_t    pcp1;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP     = 32'h0;
  localparam word_pc_t    PC_ZERO = 30'h0;

  function automatic word_pc_t pc_inc(input word_pc_t pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue of {pcp1, instr} entries with a flush that empties it
// in one cycle; push and pop are both ignored while flushing.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] EMPTY = (PW+1)'(0);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // guards keep the queue consistent even if a caller breaks the credit rule
    pop_ok   = pop && (count_q != EMPTY);
    push_ok  = push && ((count_q != FULL) || pop_ok);
    if (flush) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = EMPTY;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues one IM read per cycle under a credit rule,
// queues responses with their PC+1 and presents the queue head to ID.
module if_prefetch
  import if_pkg::*;
#(
  parameter int       DEPTH    = 4,
  parameter int       IM_AW    = 14,
  parameter word_pc_t RESET_PC = 30'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [29:0]      redirect_pc,
  output logic             im_ce,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [29:0]      id_pcp1
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] EMPTY = (PW+1)'(0);

  word_pc_t     fetch_pc_q, fetch_pc_d;
  word_pc_t     infl_pc_q, infl_pc_d;
  logic         inflight_q, inflight_d;
  word_pc_t     issue_pc;
  logic         issue, push, pop;
  logic [PW:0]  fifo_count, occupancy;
  fetch_entry_t fifo_head, push_entry;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // issue credit, PC sequencing and head presentation
  always_comb begin
    id_valid   = (fifo_count != EMPTY) && !rst;
    pop        = id_valid && id_ready;
    // an in-flight read already owns a slot, so it counts against the queue
    occupancy  = fifo_count + {{PW{1'b0}}, inflight_q};
    issue      = !rst && (redirect_valid || (occupancy < FULL) ||
                          ((occupancy == FULL) && pop));
    issue_pc   = redirect_valid ? redirect_pc : fetch_pc_q;
    im_ce      = issue;
    im_addr    = issue_pc[IM_AW-1:0];
    push       = inflight_q && !redirect_valid && !rst;
    push_entry = '{pcp1: pc_inc(infl_pc_q), instr: im_rdata};
    inflight_d = issue;
    if (issue) begin
      fetch_pc_d = pc_inc(issue_pc);
      infl_pc_d  = issue_pc;
    end else begin
      fetch_pc_d = fetch_pc_q;
      infl_pc_d  = infl_pc_q;
    end
    if (id_valid) begin
      id_instr = fifo_head.instr;
      id_pcp1  = fifo_head.pcp1;
    end else begin
      id_instr = NOP;
      id_pcp1  = PC_ZERO;
    end
  end

  // fetch PC and in-flight tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= PC_ZERO;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized and directed bench for if_prefetch against a queue-based
// transaction model of the fetch pipeline; IM holds word n at value n+0x100.
module tb_if_prefetch;

  localparam int DEPTH = 4;
  localparam int IM_AW = 14;
  localparam logic [29:0] RESET_PC = 30'h0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [29:0]      redirect_pc = 30'h0;
  logic             im_ce;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata = 32'h0;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic [31:0]      id_instr;
  logic [29:0]      id_pcp1;

  int checks = 0;
  int errors = 0;

  logic [61:0] m_q[$];
  logic        m_infl = 1'b0;
  logic [29:0] m_ipc  = 30'h0;
  logic [29:0] m_pc   = RESET_PC;

  logic             obs_ce, obs_valid;
  logic [IM_AW-1:0] obs_addr;
  logic [31:0]      obs_instr;
  logic [29:0]      obs_pcp1;

  if_prefetch #(.DEPTH(DEPTH), .IM_AW(IM_AW), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_ce          (im_ce),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pcp1        (id_pcp1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imfn(input logic [IM_AW-1:0] a);
    return 32'h100 + {{(32-IM_AW){1'b0}}, a};
  endfunction

  // instruction memory: one-cycle read latency
  always @(posedge clk) begin
    if (im_ce) im_rdata <= imfn(im_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [29:0] rpc, input logic rdy);
    logic        e_valid, e_ce, e_pop;
    logic [31:0] e_instr;
    logic [29:0] e_pcp1, ipc;
    int          occ;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    #1;
    e_valid = !r && (m_q.size() != 0);
    e_instr = e_valid ? m_q[0][31:0]  : 32'h0;
    e_pcp1  = e_valid ? m_q[0][61:32] : 30'h0;
    e_pop   = e_valid && rdy;
    occ     = m_q.size() + int'(m_infl);
    e_ce    = !r && (rv || occ < DEPTH || (occ == DEPTH && e_pop));
    ipc     = rv ? rpc : m_pc;
    obs_ce = im_ce; obs_addr = im_addr; obs_valid = id_valid;
    obs_instr = id_instr; obs_pcp1 = id_pcp1;
    check_eq("im_ce", {63'h0, obs_ce}, {63'h0, e_ce});
    if (e_ce) check_eq("im_addr", {50'h0, obs_addr}, {50'h0, ipc[IM_AW-1:0]});
    check_eq("id_valid", {63'h0, obs_valid}, {63'h0, e_valid});
    check_eq("id_instr", {32'h0, obs_instr}, {32'h0, e_instr});
    check_eq("id_pcp1", {34'h0, obs_pcp1}, {34'h0, e_pcp1});
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_infl = 1'b0; m_pc = RESET_PC;
    end else begin
      if (rv) m_q.delete();
      else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back({m_ipc + 30'd1, imfn(m_ipc[IM_AW-1:0])});
      end
      m_infl = e_ce;
      if (e_ce) begin
        m_ipc = ipc;
        m_pc  = ipc + 30'd1;
      end
    end
  endtask

  initial begin
    logic [31:0] h;
    logic [29:0] rpc;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 30'h0, 1'b1);
    check_eq("rst_ce", {63'h0, obs_ce}, 64'h0);
    check_eq("rst_valid", {63'h0, obs_valid}, 64'h0);

    // first issue at RESET_PC, data two cycles later
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("first_ce", {63'h0, obs_ce}, 64'h1);
    check_eq("first_addr", {50'h0, obs_addr}, 64'h0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("lat_valid0", {63'h0, obs_valid}, 64'h0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("lat_instr0", {32'h0, obs_instr}, 64'h100);
    check_eq("lat_pcp1_0", {34'h0, obs_pcp1}, 64'h1);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("lat_instr1", {32'h0, obs_instr}, 64'h101);
    check_eq("lat_pcp1_1", {34'h0, obs_pcp1}, 64'h2);

    // backpressure fills the queue to exactly DEPTH
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 30'h0, 1'b0);
    check_eq("full_no_issue", {63'h0, obs_ce}, 64'h0);
    check_eq("full_count", m_q.size(), 64'd4);
    h = m_q[0][31:0];
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 30'h0, 1'b1);
      check_eq("drain_order", {32'h0, obs_instr}, {32'h0, h + 32'(i)});
    end

    // redirect flushes the queue and issues at the target
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 30'h0, 1'b0);
    cycle(1'b0, 1'b1, 30'h40, 1'b1);
    check_eq("redir_addr", {50'h0, obs_addr}, 64'h40);
    check_eq("redir_ce", {63'h0, obs_ce}, 64'h1);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("redir_flush", {63'h0, obs_valid}, 64'h0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("redir_instr", {32'h0, obs_instr}, 64'h140);
    check_eq("redir_pcp1", {34'h0, obs_pcp1}, 64'h41);

    // PC wrap at the top of the word address space
    cycle(1'b0, 1'b1, 30'h3FFFFFFF, 1'b1);
    check_eq("wrap_addr0", {50'h0, obs_addr}, 64'h3FFF);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("wrap_addr1", {50'h0, obs_addr}, 64'h0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("wrap_pcp1", {34'h0, obs_pcp1}, 64'h0);
    check_eq("wrap_instr", {32'h0, obs_instr}, 64'h40FF);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("wrap_pcp1_next", {34'h0, obs_pcp1}, 64'h1);

    // reset with three queued entries and one in flight
    cycle(1'b0, 1'b1, 30'h200, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 30'h0, 1'b0);
    check_eq("pre_rst_count", m_q.size(), 64'd3);
    cycle(1'b1, 1'b0, 30'h0, 1'b0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("post_rst_valid", {63'h0, obs_valid}, 64'h0);
    check_eq("post_rst_instr", {32'h0, obs_instr}, 64'h0);
    check_eq("post_rst_addr", {50'h0, obs_addr}, 64'h0);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    cycle(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("post_rst_first", {32'h0, obs_instr}, 64'h100);

    // random backpressure and redirects
    for (int i = 0; i < 3000; i++) begin
      rpc = 30'($urandom());
      if ($urandom_range(0, 3) == 0) rpc = 30'h3FFFFFF8 + 30'($urandom_range(0, 7));
      cycle(1'b0, ($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
